// File: rtl/secuenciador_pc.sv
// secuenciador_pc: fetch sequencer owning the PC, fetch handshake, next-PC selection, retire count and fetch timeout
module secuenciador_pc #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ack,
    input  logic        stall,
    input  logic        SaltoCond,
    input  logic        zero,
    input  logic        Salto,
    input  logic [31:0] extSigno,
    input  logic [25:0] dirSalto,
    output logic        mem_req,
    output logic [31:0] dirLectura,
    output logic [31:0] pc_mas4,
    output logic        instr_valid,
    output logic [31:0] num_instr,
    output logic        error
);
    typedef enum logic [1:0] {INICIO, FETCH, EXEC, HALT} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d, num_q, num_d, off, next_pc;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d, run_q, mem_req_q, instr_valid_q;
    assign pc_mas4     = pc_q + 32'd4;
    assign off         = extSigno << 2;
    assign next_pc     = Salto ? {pc_mas4[31:28], dirSalto, 2'b00} :
                         (SaltoCond && zero) ? pc_mas4 + off : pc_mas4;
    assign mem_req     = mem_req_q;
    assign instr_valid = instr_valid_q;
    assign dirLectura  = pc_q;
    assign num_instr   = num_q;
    assign error       = err_q;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        num_d   = num_q;
        err_d   = err_q;
        cnt_d   = '0;
        unique case (state_q)
            INICIO: state_d = run_q ? FETCH : INICIO;
            FETCH: begin
                if (mem_ack) state_d = EXEC;
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = HALT;
                    err_d   = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            end
            EXEC: begin
                if (!stall) begin
                    pc_d    = next_pc;
                    num_d   = num_q + 32'd1;
                    state_d = FETCH;
                end
            end
            default: state_d = HALT;
        endcase
    end
    // run_q delays INICIO one cycle so the first edge after release only leaves reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= INICIO;
            pc_q          <= RESET_ADDR;
            num_q         <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            run_q         <= 1'b0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            num_q         <= num_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            run_q         <= 1'b1;
            mem_req_q     <= (state_d == FETCH);
            instr_valid_q <= (state_d == EXEC);
        end
    end
endmodule

// File: tb/tb_secuenciador_pc.sv
// tb_secuenciador_pc: directed checks of fetch sequencing, next-PC selection, stall, timeout and reset
module tb_secuenciador_pc;
    logic        clk = 1'b0, rst_n = 1'b0, mem_ack = 1'b0, stall = 1'b0;
    logic        SaltoCond = 1'b0, zero = 1'b0, Salto = 1'b0;
    logic [31:0] extSigno = '0;
    logic [25:0] dirSalto = '0;
    logic        mem_req, instr_valid, error;
    logic [31:0] dirLectura, pc_mas4, num_instr;
    int          n_tests = 0, n_fail = 0;
    always #5 clk = ~clk;
    secuenciador_pc dut (
        .clk(clk), .rst_n(rst_n), .mem_ack(mem_ack), .stall(stall),
        .SaltoCond(SaltoCond), .zero(zero), .Salto(Salto),
        .extSigno(extSigno), .dirSalto(dirSalto), .mem_req(mem_req),
        .dirLectura(dirLectura), .pc_mas4(pc_mas4), .instr_valid(instr_valid),
        .num_instr(num_instr), .error(error)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic clear_ctl;
        SaltoCond = 1'b0; zero = 1'b0; Salto = 1'b0; extSigno = '0; dirSalto = '0;
    endtask
    task automatic do_reset;
        rst_n = 1'b0; mem_ack = 1'b0; stall = 1'b0;
        clear_ctl();
        #2 rst_n = 1'b1;
        tick();
        tick();
    endtask
    // one instruction from FETCH (mem_ack high) through EXEC back to FETCH
    task automatic instr(input logic [31:0] pc, input logic [31:0] nxt, input string tag);
        chk({tag, "_fetch_pc"}, dirLectura, pc);
        chk({tag, "_fetch_req"}, {31'b0, mem_req}, 32'd1);
        tick();
        chk({tag, "_exec_valid"}, {31'b0, instr_valid}, 32'd1);
        chk({tag, "_exec_req"}, {31'b0, mem_req}, 32'd0);
        tick();
        chk({tag, "_next_pc"}, dirLectura, nxt);
        chk({tag, "_pc_mas4"}, pc_mas4, nxt + 32'd4);
    endtask
    initial begin
        #3;
        chk("rst_pc", dirLectura, 32'h0);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_num", num_instr, 32'd0);
        chk("rst_err", {31'b0, error}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("inicio_req", {31'b0, mem_req}, 32'd0);
        tick();
        chk("first_fetch_req", {31'b0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        instr(32'h0, 32'h4, "seq0");
        instr(32'h4, 32'h8, "seq1");
        SaltoCond = 1'b1; zero = 1'b1; extSigno = 32'hC000_0001;
        instr(32'h8, 32'h10, "br_taken");
        chk("num_after3", num_instr, 32'd3);
        do_reset();
        mem_ack = 1'b1;
        instr(32'h0, 32'h4, "r_seq0");
        instr(32'h4, 32'h8, "r_seq1");
        SaltoCond = 1'b1; zero = 1'b0; extSigno = 32'hC000_0001;
        instr(32'h8, 32'hC, "br_not_taken");
        zero = 1'b1; extSigno = 32'h03FF_FFFC;
        instr(32'hC, 32'h1000_0000, "br_far");
        Salto = 1'b1; dirSalto = 26'h000_0040;
        instr(32'h1000_0000, 32'h1000_0100, "jump_over_br");
        Salto = 1'b0; extSigno = 32'hFBFF_FFBF;
        instr(32'h1000_0100, 32'h0, "pc_wrap");
        chk("num_after6", num_instr, 32'd6);
        clear_ctl();
        stall = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_pc", dirLectura, 32'h0);
            chk("stall_num", num_instr, 32'd6);
            if (i == 3) stall = 1'b0;
            tick();
        end
        chk("post_stall_valid", {31'b0, instr_valid}, 32'd0);
        chk("post_stall_pc", dirLectura, 32'h4);
        chk("post_stall_num", num_instr, 32'd7);
        mem_ack = 1'b0;
        repeat (15) tick();
        chk("late_ack_req", {31'b0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        tick();
        chk("late_ack_valid", {31'b0, instr_valid}, 32'd1);
        chk("late_ack_err", {31'b0, error}, 32'd0);
        tick();
        chk("late_ack_pc", dirLectura, 32'h8);
        mem_ack = 1'b0;
        repeat (15) tick();
        chk("to_15_req", {31'b0, mem_req}, 32'd1);
        chk("to_15_err", {31'b0, error}, 32'd0);
        tick();
        chk("to_16_err", {31'b0, error}, 32'd1);
        chk("to_16_req", {31'b0, mem_req}, 32'd0);
        mem_ack = 1'b1;
        repeat (4) tick();
        chk("halt_req", {31'b0, mem_req}, 32'd0);
        chk("halt_valid", {31'b0, instr_valid}, 32'd0);
        chk("halt_err", {31'b0, error}, 32'd1);
        chk("halt_pc", dirLectura, 32'h8);
        chk("halt_num", num_instr, 32'd8);
        do_reset();
        chk("rst_clears_err", {31'b0, error}, 32'd0);
        mem_ack = 1'b1;
        SaltoCond = 1'b1; zero = 1'b1; extSigno = 32'd7;
        instr(32'h0, 32'h20, "to_20");
        clear_ctl();
        mem_ack = 1'b0;
        tick();
        chk("mid_fetch_req", {31'b0, mem_req}, 32'd1);
        chk("mid_fetch_num", num_instr, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", {31'b0, mem_req}, 32'd0);
        chk("async_rst_pc", dirLectura, 32'h0);
        chk("async_rst_num", num_instr, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("restart_c0_req", {31'b0, mem_req}, 32'd0);
        tick();
        chk("restart_c1_req", {31'b0, mem_req}, 32'd1);
        chk("restart_c1_pc", dirLectura, 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
